// File: rtl/filter_unit_datapath_if.sv
// Command, sample, coefficient-write and output signals between the FIR
// control FSM / sample source (master) and the filter datapath (slave).
interface filter_unit_datapath_if #(
  parameter int DATABITS  = 16,
  parameter int COEFFBITS = 16,
  parameter int FADDRBITS = 3
);
  logic                 clr_in;
  logic                 dwe_in;
  logic [FADDRBITS-1:0] faddr_in;
  logic [1:0]           mctrl_in;
  logic                 oload_in;
  logic [DATABITS-1:0]  d_in;
  logic                 cwe_in;
  logic [FADDRBITS-1:0] caddr_in;
  logic [COEFFBITS-1:0] cdata_in;
  logic [DATABITS-1:0]  d_out;
  logic                 valid_out;
  logic                 sat_out;

  modport master (
    output clr_in, dwe_in, faddr_in, mctrl_in, oload_in, d_in,
           cwe_in, caddr_in, cdata_in,
    input  d_out, valid_out, sat_out
  );

  modport slave (
    input  clr_in, dwe_in, faddr_in, mctrl_in, oload_in, d_in,
           cwe_in, caddr_in, cdata_in,
    output d_out, valid_out, sat_out
  );
endinterface

// File: rtl/filter_unit_datapath.sv
// FIR filter datapath: sample delay line, coefficient file, MAC accumulator and
// saturating output register, all sequenced cycle by cycle by the control FSM.
module filter_unit_datapath #(
  parameter int DATABITS  = 16,
  parameter int COEFFBITS = 16,
  parameter int NTAPS     = 7,
  parameter int FADDRBITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  filter_unit_datapath_if.slave bus
);
  localparam int PRODBITS = DATABITS + COEFFBITS;
  localparam int ACCBITS  = DATABITS + COEFFBITS + FADDRBITS;
  localparam logic [FADDRBITS-1:0] LAST_TAP = FADDRBITS'(NTAPS - 1);

  localparam logic signed [ACCBITS-1:0] SAT_MAX =
    {{(ACCBITS-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
  localparam logic signed [ACCBITS-1:0] SAT_MIN =
    {{(ACCBITS-DATABITS+1){1'b1}}, {(DATABITS-1){1'b0}}};
  localparam logic signed [DATABITS-1:0] OUT_MAX = {1'b0, {(DATABITS-1){1'b1}}};
  localparam logic signed [DATABITS-1:0] OUT_MIN = {1'b1, {(DATABITS-1){1'b0}}};

  typedef enum logic [1:0] {
    MAC_NOP  = 2'b00,
    MAC_CLR  = 2'b01,
    MAC_LOAD = 2'b10,
    MAC_ACC  = 2'b11
  } mac_cmd_e;

  logic signed [DATABITS-1:0]  x_q [NTAPS];
  logic signed [COEFFBITS-1:0] c_q [NTAPS];
  logic signed [ACCBITS-1:0]   acc_q;

  logic signed [DATABITS-1:0]  x_sel;
  logic signed [COEFFBITS-1:0] c_sel;
  logic signed [PRODBITS-1:0]  prod;
  logic signed [ACCBITS-1:0]   prod_ext;
  logic signed [ACCBITS-1:0]   acc_next;
  logic signed [ACCBITS-1:0]   scaled;
  logic signed [DATABITS-1:0]  sat_val;
  logic                        sat_hit;
  logic                        tap_ok;
  logic                        caddr_ok;

  assign tap_ok   = (bus.faddr_in <= LAST_TAP);
  assign caddr_ok = (bus.caddr_in <= LAST_TAP);

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    x_sel = '0;
    c_sel = '0;
    if (tap_ok) begin
      x_sel = x_q[bus.faddr_in];
      c_sel = c_q[bus.faddr_in];
    end
    prod     = PRODBITS'(x_sel) * PRODBITS'(c_sel);
    prod_ext = {{FADDRBITS{prod[PRODBITS-1]}}, prod};

    unique case (mac_cmd_e'(bus.mctrl_in))
      MAC_CLR:  acc_next = '0;
      MAC_LOAD: acc_next = prod_ext;
      MAC_ACC:  acc_next = acc_q + prod_ext;
      default:  acc_next = acc_q;
    endcase

    // Arithmetic shift floors, giving truncation toward -inf back to Q0.
    scaled  = acc_next >>> (COEFFBITS - 1);
    sat_hit = 1'b1;
    if (scaled > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (scaled < SAT_MIN) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = scaled[DATABITS-1:0];
      sat_hit = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking '<=' so every
  // register samples pre-edge values, which the same-cycle MAC/shift relies on.
  // NOTE: the coefficient file is a reset register array rather than a RAM,
  // since reset must leave every coefficient at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q         <= '0;
      bus.d_out     <= '0;
      bus.valid_out <= 1'b0;
      bus.sat_out   <= 1'b0;
    end else begin
      acc_q <= acc_next;

      if (bus.cwe_in && caddr_ok) begin
        c_q[bus.caddr_in] <= bus.cdata_in;
      end

      if (bus.clr_in) begin
        for (int i = 0; i < NTAPS; i++) begin
          x_q[i] <= '0;
        end
        bus.d_out     <= '0;
        bus.valid_out <= 1'b0;
        bus.sat_out   <= 1'b0;
      end else begin
        if (bus.dwe_in) begin
          x_q[0] <= bus.d_in;
          for (int i = 1; i < NTAPS; i++) begin
            x_q[i] <= x_q[i-1];
          end
        end
        bus.valid_out <= bus.oload_in;
        if (bus.oload_in) begin
          bus.d_out <= sat_val;
          if (sat_hit) begin
            bus.sat_out <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_filter_unit_datapath.sv
// Directed bench for filter_unit_datapath: drives control-FSM style passes and
// compares outputs against hand-computed values.
module tb_filter_unit_datapath;
  localparam logic [1:0] MAC_NOP  = 2'b00;
  localparam logic [1:0] MAC_CLR  = 2'b01;
  localparam logic [1:0] MAC_LOAD = 2'b10;
  localparam logic [1:0] MAC_ACC  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  filter_unit_datapath_if #(.DATABITS(16), .COEFFBITS(16), .FADDRBITS(3)) bus ();

  filter_unit_datapath #(
    .DATABITS(16), .COEFFBITS(16), .NTAPS(7), .FADDRBITS(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic defaults();
    bus.clr_in   = 1'b0;
    bus.dwe_in   = 1'b0;
    bus.faddr_in = 3'd0;
    bus.mctrl_in = MAC_NOP;
    bus.oload_in = 1'b0;
    bus.d_in     = 16'h0000;
    bus.cwe_in   = 1'b0;
    bus.caddr_in = 3'd0;
    bus.cdata_in = 16'h0000;
  endtask

  // One clock with the currently driven inputs; outputs are stable 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
    bus.cwe_in   = 1'b1;
    bus.caddr_in = addr;
    bus.cdata_in = data;
    tick();
  endtask

  task automatic shift_in(input logic [15:0] sample);
    bus.dwe_in = 1'b1;
    bus.d_in   = sample;
    tick();
  endtask

  // Full TAP0..TAP6 pass; the last tap also shifts in the next sample and loads d_out.
  task automatic run_pass(input logic [15:0] next_sample, output int early_valid);
    early_valid = 0;
    for (int k = 0; k < 7; k++) begin
      bus.faddr_in = 3'(k);
      bus.mctrl_in = (k == 0) ? MAC_LOAD : MAC_ACC;
      if (k == 6) begin
        bus.oload_in = 1'b1;
        bus.dwe_in   = 1'b1;
        bus.d_in     = next_sample;
      end
      tick();
      if (k < 6 && bus.valid_out) early_valid++;
    end
  endtask

  task automatic test_reset();
    int ev;
    tick();
    tick();
    total++;
    if ({bus.d_out, bus.valid_out, bus.sat_out} !== 18'h0)
      $display("FAIL reset_init outputs got %h want 0", {bus.d_out, bus.valid_out, bus.sat_out});
    else passed++;
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) write_coef(3'(k), 16'h7FFF);
    for (int k = 0; k < 7; k++) shift_in(16'h1000);
    run_pass(16'h1000, ev);
    total++;
    if (bus.d_out !== 16'h6FFF) $display("FAIL reset_prepass d_out got %h want 6fff", bus.d_out);
    else passed++;

    // Partial pass so acc holds a nonzero sum, then reset between edges.
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; tick();
    bus.faddr_in = 3'd1; bus.mctrl_in = MAC_ACC;  tick();
    bus.faddr_in = 3'd2; bus.mctrl_in = MAC_ACC;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.d_out, bus.valid_out, bus.sat_out} !== 18'h0)
      $display("FAIL reset_async outputs got %h want 0", {bus.d_out, bus.valid_out, bus.sat_out});
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    defaults();

    // ACC on a cleared accumulator with zero product must still read zero.
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_ACC; bus.oload_in = 1'b1;
    tick();
    total++;
    if (bus.d_out !== 16'h0000) $display("FAIL reset_acc d_out got %h want 0000", bus.d_out);
    else passed++;
    total++;
    if (bus.valid_out !== 1'b1) $display("FAIL reset_acc valid got %b want 1", bus.valid_out);
    else passed++;

    for (int k = 0; k < 7; k++) shift_in(16'h1000);
    run_pass(16'h1000, ev);
    total++;
    if (bus.d_out !== 16'h0000) $display("FAIL reset_coef d_out got %h want 0000", bus.d_out);
    else passed++;
  endtask

  task automatic test_impulse();
    logic [15:0] exp_out [8];
    int ev;
    exp_out = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3FFF,
                16'h4FFF, 16'h5FFF, 16'h6FFF, 16'h0000};
    bus.clr_in = 1'b1; bus.mctrl_in = MAC_CLR; tick();
    for (int k = 0; k < 7; k++) write_coef(3'(k), 16'((k + 1) * 16'h1000));
    shift_in(16'h7FFF);
    for (int p = 0; p < 8; p++) begin
      run_pass(16'h0000, ev);
      total++;
      if (bus.d_out !== exp_out[p])
        $display("FAIL impulse[%0d] d_out got %h want %h", p, bus.d_out, exp_out[p]);
      else passed++;
      total++;
      if (bus.valid_out !== 1'b1 || ev != 0)
        $display("FAIL impulse[%0d] valid got %b early=%0d want 1 early=0", p, bus.valid_out, ev);
      else passed++;
      tick();
      total++;
      if (bus.valid_out !== 1'b0)
        $display("FAIL impulse[%0d] valid_drop got %b want 0", p, bus.valid_out);
      else passed++;
    end
    total++;
    if (bus.sat_out !== 1'b0) $display("FAIL impulse sat_out got %b want 0", bus.sat_out);
    else passed++;
  endtask

  task automatic test_saturation();
    int ev;
    for (int k = 0; k < 7; k++) write_coef(3'(k), 16'h7FFF);
    for (int k = 0; k < 7; k++) shift_in(16'h7FFF);
    run_pass(16'h7FFF, ev);
    total++;
    if (bus.d_out !== 16'h7FFF || bus.sat_out !== 1'b1)
      $display("FAIL sat_pos d_out/sat got %h/%b want 7fff/1", bus.d_out, bus.sat_out);
    else passed++;
    for (int k = 0; k < 7; k++) shift_in(16'h8000);
    run_pass(16'h8000, ev);
    total++;
    if (bus.d_out !== 16'h8000 || bus.sat_out !== 1'b1)
      $display("FAIL sat_neg d_out/sat got %h/%b want 8000/1", bus.d_out, bus.sat_out);
    else passed++;
    tick();
    total++;
    if (bus.sat_out !== 1'b1) $display("FAIL sat_sticky got %b want 1", bus.sat_out);
    else passed++;
    bus.clr_in = 1'b1; bus.mctrl_in = MAC_CLR; tick();
    total++;
    if (bus.sat_out !== 1'b0 || bus.d_out !== 16'h0000)
      $display("FAIL sat_clr d_out/sat got %h/%b want 0000/0", bus.d_out, bus.sat_out);
    else passed++;
  endtask

  task automatic test_last_tap_overlap();
    for (int k = 0; k < 7; k++) write_coef(3'(k), 16'h0000);
    write_coef(3'd0, 16'h4000);
    write_coef(3'd6, 16'h4000);
    shift_in(16'h1000);
    for (int k = 0; k < 6; k++) shift_in(16'h0000);
    bus.faddr_in = 3'd6; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1;
    bus.dwe_in = 1'b1; bus.d_in = 16'h2000;
    tick();
    total++;
    if (bus.d_out !== 16'h0800) $display("FAIL overlap_old_x6 d_out got %h want 0800", bus.d_out);
    else passed++;
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1;
    tick();
    total++;
    if (bus.d_out !== 16'h1000) $display("FAIL overlap_new_x0 d_out got %h want 1000", bus.d_out);
    else passed++;
  endtask

  task automatic test_clr_mid_pass();
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1; bus.clr_in = 1'b1;
    tick();
    total++;
    if (bus.d_out !== 16'h0000 || bus.valid_out !== 1'b0)
      $display("FAIL clr_oload d_out/valid got %h/%b want 0000/0", bus.d_out, bus.valid_out);
    else passed++;
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; tick();
    bus.faddr_in = 3'd6; bus.mctrl_in = MAC_ACC; bus.oload_in = 1'b1; tick();
    total++;
    if (bus.d_out !== 16'h0000) $display("FAIL clr_x_zero d_out got %h want 0000", bus.d_out);
    else passed++;
    shift_in(16'h2000);
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1; tick();
    total++;
    if (bus.d_out !== 16'h1000) $display("FAIL clr_coef_kept d_out got %h want 1000", bus.d_out);
    else passed++;
  endtask

  task automatic test_coef_write();
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1;
    bus.cwe_in = 1'b1; bus.caddr_in = 3'd0; bus.cdata_in = 16'h7FFF;
    tick();
    total++;
    if (bus.d_out !== 16'h1000) $display("FAIL coef_old d_out got %h want 1000", bus.d_out);
    else passed++;
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1; tick();
    total++;
    if (bus.d_out !== 16'h1FFF) $display("FAIL coef_new d_out got %h want 1fff", bus.d_out);
    else passed++;
    bus.faddr_in = 3'd7; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1; tick();
    total++;
    if (bus.d_out !== 16'h0000) $display("FAIL faddr_oob d_out got %h want 0000", bus.d_out);
    else passed++;
    write_coef(3'd0, 16'h4000);
    shift_in(16'hFFFF);
    bus.faddr_in = 3'd0; bus.mctrl_in = MAC_LOAD; bus.oload_in = 1'b1; tick();
    total++;
    if (bus.d_out !== 16'hFFFF) $display("FAIL trunc_neg d_out got %h want ffff", bus.d_out);
    else passed++;
  endtask

  initial begin
    defaults();
    test_reset();
    test_impulse();
    test_saturation();
    test_last_tap_overlap();
    test_clr_mid_pass();
    test_coef_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
